// File: rtl/calc_pkg.sv
// Shared types for the calculator scheduler: operation codes, FSM states and
// the opcode legality helper.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_POW = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'(OP_POW);
  endfunction

endpackage

// File: rtl/calc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above ptr, wrapping modulo NREQ. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_scheduler.sv
// Round-robin scheduler sharing one external combinational calculator among
// NREQ requesters. Optional illegal-opcode check: define CALC_SCHED_OPCHK_EN.
module calc_scheduler
  import calc_pkg::*;
#(
  parameter int NB   = 64,
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*NB-1:0]      req_a,
  input  logic [NREQ*NB-1:0]      req_b,
  input  logic [NREQ*3-1:0]       req_op,
  output logic [NB-1:0]           calc_a,
  output logic [NB-1:0]           calc_b,
  output logic [2:0]              calc_op,
  input  logic [NB-1:0]           calc_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [NB-1:0]           rsp_result,
  output logic                    rsp_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LAT + 1);

  sched_state_e    state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] gnt;
  logic            any_req;
  logic            win_legal;
  logic [2:0]      win_op;
  logic [CW-1:0]   cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = IW'(i);
    end
  end

  assign any_req   = |gnt;
  assign win_op    = req_op[win_idx*3 +: 3];
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign rsp_valid = (state == RESP);

`ifdef CALC_SCHED_OPCHK_EN
  assign win_legal = is_legal_op(win_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           rsp_err <= 1'b0;
    else if (state == IDLE && any_req) rsp_err <= !win_legal;
  end
`else
  assign win_legal = 1'b1;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = win_legal ? EXEC : RESP;
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      calc_op    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          rsp_id <= win_idx;
          cnt    <= CW'(LAT - 1);
          // Illegal ops skip the datapath entirely and answer with zero.
          if (win_legal) begin
            calc_a  <= req_a[win_idx*NB +: NB];
            calc_b  <= req_b[win_idx*NB +: NB];
            calc_op <= win_op;
          end else begin
            rsp_result <= '0;
          end
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           rsp_result <= calc_result;
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= (rsp_id == IW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
